// File: rtl/regfile_pkg.sv
// Shared definitions for the Y86 two-read/two-write register file:
// default widths, the RNONE "no register" encoding and architectural
// register index names.
package regfile_pkg;

    localparam int DEF_NREG     = 15;
    localparam int DEF_DATA_WID = 64;
    localparam int DEF_ADDR_WID = 4;

    // All-ones address: the "no register" selector at the default address width
    localparam logic [DEF_ADDR_WID-1:0] RNONE = 4'hF;

    // Architectural register indices
    typedef enum logic [DEF_ADDR_WID-1:0] {
        RAX      = 4'd0,
        RCX      = 4'd1,
        RDX      = 4'd2,
        RBX      = 4'd3,
        RSP      = 4'd4,
        RBP      = 4'd5,
        RSI      = 4'd6,
        RDI      = 4'd7,
        R8       = 4'd8,
        R9       = 4'd9,
        R10      = 4'd10,
        R11      = 4'd11,
        R12      = 4'd12,
        R13      = 4'd13,
        R14      = 4'd14,
        REG_NONE = 4'd15
    } reg_idx_e;

    // True when an address selects a real register (RNONE and anything
    // at or beyond the register count are not real registers)
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned nreg);
        return (addr < nreg);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Load-pending scoreboard: one bit per register, set by a reservation for an
// in-flight load and cleared by the M-port write that delivers the load data.
// A reservation and a clear on the same register in one cycle leaves the bit
// set, since the reservation belongs to a newer load.
// Optional feature macro: REGFILE_BYPASS_EN (masks pendX when the M port is
// forwarding that register's data in the same cycle).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int ADDR_WID = DEF_ADDR_WID
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                resv_en,
    input  logic [ADDR_WID-1:0] resv_addr,
    input  logic [ADDR_WID-1:0] destM,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    output logic                pendA,
    output logic                pendB,
    output logic                stall
);

    logic [NREG-1:0] pend_r;
    logic [NREG-1:0] pend_nxt_s;
    logic            resv_ok_s;
    logic            clr_ok_s;
    logic            pend_a_s;
    logic            pend_b_s;

    assign resv_ok_s = resv_en & addr_ok(32'(resv_addr), NREG);
    assign clr_ok_s  = addr_ok(32'(destM), NREG);

    // Next pend vector: reservation set takes priority over M-port clear
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 0; i < NREG; i++) begin
            if (resv_ok_s && (resv_addr == ADDR_WID'(i))) begin
                pend_nxt_s[i] = 1'b1;
            end else if (clr_ok_s && (destM == ADDR_WID'(i))) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
    end

    // Pend bit storage, cleared immediately by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_r <= {NREG{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Pend lookup for both read ports; out-of-range sources never match
    always_comb begin
        pend_a_s = 1'b0;
        pend_b_s = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            pend_a_s = pend_a_s | (pend_r[i] & (srcA == ADDR_WID'(i)));
            pend_b_s = pend_b_s | (pend_r[i] & (srcB == ADDR_WID'(i)));
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Load data arriving on the M port this cycle is forwarded, so no stall
    assign pendA = pend_a_s & ~(clr_ok_s & (srcA == destM));
    assign pendB = pend_b_s & ~(clr_ok_s & (srcB == destM));
`else
    assign pendA = pend_a_s;
    assign pendB = pend_b_s;
`endif

    assign stall = pendA | pendB;

endmodule

// File: rtl/regfile_2r2w.sv
// Y86 register file with two combinational read ports, two clocked write
// ports (E and M, M wins on a collision) and a load-pending scoreboard that
// raises stall on read-after-load hazards.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle forwarding from the
// write ports to the read ports; M data takes priority over E data).
module regfile_2r2w
    import regfile_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int DATA_WID = DEF_DATA_WID,
    parameter int ADDR_WID = DEF_ADDR_WID
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    output logic [DATA_WID-1:0] valA,
    output logic [DATA_WID-1:0] valB,
    input  logic [ADDR_WID-1:0] destE,
    input  logic [DATA_WID-1:0] valE,
    input  logic [ADDR_WID-1:0] destM,
    input  logic [DATA_WID-1:0] valM,
    input  logic                resv_en,
    input  logic [ADDR_WID-1:0] resv_addr,
    output logic                pendA,
    output logic                pendB,
    output logic                stall
);

    logic [DATA_WID-1:0] regs_r [NREG];
    logic [DATA_WID-1:0] arr_a_s;
    logic [DATA_WID-1:0] arr_b_s;
    logic                e_ok_s;
    logic                m_ok_s;

    // RNONE and any address past the last register are write no-ops
    assign e_ok_s = addr_ok(32'(destE), NREG);
    assign m_ok_s = addr_ok(32'(destM), NREG);

    // Register array update: M port overrides E port on the same address
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_WID{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (m_ok_s && (destM == ADDR_WID'(i))) begin
                    regs_r[i] <= valM;
                end else if (e_ok_s && (destE == ADDR_WID'(i))) begin
                    regs_r[i] <= valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Array read mux; an address with no register behind it reads as zero
    always_comb begin
        arr_a_s = {DATA_WID{1'b0}};
        arr_b_s = {DATA_WID{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            arr_a_s = arr_a_s | (regs_r[i] & {DATA_WID{srcA == ADDR_WID'(i)}});
            arr_b_s = arr_b_s | (regs_r[i] & {DATA_WID{srcB == ADDR_WID'(i)}});
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read ports forward in-flight write data: M first, then E, then array
    always_comb begin
        if (m_ok_s && (srcA == destM)) begin
            valA = valM;
        end else if (e_ok_s && (srcA == destE)) begin
            valA = valE;
        end else begin
            valA = arr_a_s;
        end
        if (m_ok_s && (srcB == destM)) begin
            valB = valM;
        end else if (e_ok_s && (srcB == destE)) begin
            valB = valE;
        end else begin
            valB = arr_b_s;
        end
    end
`else
    // Read ports return array contents only
    always_comb begin
        valA = arr_a_s;
        valB = arr_b_s;
    end
`endif

    regfile_scoreboard #(
        .NREG     (NREG),
        .ADDR_WID (ADDR_WID)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .destM     (destM),
        .srcA      (srcA),
        .srcB      (srcB),
        .pendA     (pendA),
        .pendB     (pendB),
        .stall     (stall)
    );

endmodule

// File: tb/tb_regfile_2r2w.sv
// Self-checking bench for regfile_2r2w: directed scenarios plus randomized
// traffic, compared against a behavioural array/scoreboard model.
// Honours REGFILE_BYPASS_EN in the model when the build defines it.
module tb_regfile_2r2w;
    import regfile_pkg::*;

    localparam int NREG = 15;

    logic        CLK;
    logic        RST;
    logic [3:0]  srcA, srcB, destE, destM, resv_addr;
    logic [63:0] valA, valB, valE, valM;
    logic        resv_en, pendA, pendB, stall;

    int n_checks;
    int n_errors;

    logic [63:0] m_reg  [NREG];
    bit          m_pend [NREG];
    logic [63:0] ev_a, ev_b;
    logic        ep_a, ep_b, e_stall;

    regfile_2r2w #(.NREG(15), .DATA_WID(64), .ADDR_WID(4)) dut (
        .CLK(CLK), .RST(RST), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .destE(destE), .valE(valE), .destM(destM), .valM(valM),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .pendA(pendA), .pendB(pendB), .stall(stall)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [63:0] model_read(input logic [3:0] src);
        if (int'(src) >= NREG) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (destM == src) return valM;
        if (destE == src) return valE;
`endif
        return m_reg[src];
    endfunction

    function automatic logic model_pend(input logic [3:0] src);
        if (int'(src) >= NREG) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (destM == src) return 1'b0;
`endif
        return m_pend[src];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = 64'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_expect();
        ev_a    = model_read(srcA);
        ev_b    = model_read(srcB);
        ep_a    = model_pend(srcA);
        ep_b    = model_pend(srcB);
        e_stall = ep_a | ep_b;
    endtask

    // Apply one clock edge to the model: later statements take priority
    task automatic model_clock();
        if (int'(destE) < NREG) m_reg[destE] = valE;
        if (int'(destM) < NREG) begin
            m_reg[destM]  = valM;
            m_pend[destM] = 1'b0;
        end
        if (resv_en && int'(resv_addr) < NREG) m_pend[resv_addr] = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic idle();
        destE     = RNONE;
        destM     = RNONE;
        valE      = 64'd0;
        valM      = 64'd0;
        resv_en   = 1'b0;
        resv_addr = 4'd0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle();
        srcA = 4'd0;
        srcB = 4'd14;
        model_reset();
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        n_checks++; if (valA !== 64'd0) begin n_errors++; $display("FAIL reset_valA: got %h expected 0", valA); end
        n_checks++; if (valB !== 64'd0) begin n_errors++; $display("FAIL reset_valB: got %h expected 0", valB); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if ({pendA, pendB} !== 2'b00) begin n_errors++; $display("FAIL reset_pend: got %b%b expected 00", pendA, pendB); end
    endtask

    task automatic test_dual_write();
        destE = 4'd2; valE = 64'h11;
        destM = 4'd3; valM = 64'h22;
        tick();
        idle();
        srcA = 4'd2;
        srcB = 4'd3;
        #1;
        n_checks++; if (valA !== 64'h11) begin n_errors++; $display("FAIL dual_valA: got %h expected 11", valA); end
        n_checks++; if (valB !== 64'h22) begin n_errors++; $display("FAIL dual_valB: got %h expected 22", valB); end
    endtask

    task automatic test_collision();
        destE = 4'd4; valE = 64'hAA;
        destM = 4'd4; valM = 64'hBB;
        tick();
        destE = 4'd5; valE = 64'h5E;
        destM = RNONE; valM = 64'hFFFF;
        tick();
        destE = 4'd15; valE = 64'hDEAD;
        destM = 4'd15; valM = 64'hBEEF;
        tick();
        idle();
        srcA = 4'd4;
        srcB = 4'd5;
        #1;
        n_checks++; if (valA !== 64'hBB) begin n_errors++; $display("FAIL collide_reg4: got %h expected bb", valA); end
        n_checks++; if (valB !== 64'h5E) begin n_errors++; $display("FAIL e_only_reg5: got %h expected 5e", valB); end
        srcA = 4'd15;
        srcB = 4'd14;
        #1;
        n_checks++; if (valA !== 64'd0) begin n_errors++; $display("FAIL rnone_read: got %h expected 0", valA); end
        n_checks++; if (valB !== 64'd0) begin n_errors++; $display("FAIL reg14_untouched: got %h expected 0", valB); end
    endtask

    task automatic test_hazard();
        resv_en = 1'b1; resv_addr = 4'd6;
        tick();
        idle();
        srcA = 4'd6;
        srcB = 4'd0;
        #1;
        n_checks++; if (pendA !== 1'b1) begin n_errors++; $display("FAIL hazard_pendA: got %b expected 1", pendA); end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL hazard_stall: got %b expected 1", stall); end
        destM = 4'd6; valM = 64'h5;
        #1;
        model_expect();
        n_checks++; if (valA !== ev_a) begin n_errors++; $display("FAIL hazard_fwd_valA: got %h expected %h", valA, ev_a); end
        n_checks++; if (stall !== e_stall) begin n_errors++; $display("FAIL hazard_fwd_stall: got %b expected %b", stall, e_stall); end
        tick();
        idle();
        #1;
        n_checks++; if (valA !== 64'h5) begin n_errors++; $display("FAIL hazard_after_valA: got %h expected 5", valA); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL hazard_after_stall: got %b expected 0", stall); end
    endtask

    task automatic test_set_clear();
        resv_en = 1'b1; resv_addr = 4'd7;
        tick();
        destM = 4'd7; valM = 64'h77;
        srcA = 4'd0;
        tick();
        idle();
        srcA = 4'd7;
        #1;
        n_checks++; if (pendA !== 1'b1) begin n_errors++; $display("FAIL setclr_pendA: got %b expected 1", pendA); end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL setclr_stall: got %b expected 1", stall); end
        n_checks++; if (valA !== 64'h77) begin n_errors++; $display("FAIL setclr_valA: got %h expected 77", valA); end
        destM = 4'd7; valM = 64'h78;
        tick();
        idle();
        #1;
        n_checks++; if (pendA !== 1'b0) begin n_errors++; $display("FAIL setclr_release: got %b expected 0", pendA); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            srcA      = 4'($urandom_range(0, 15));
            srcB      = 4'($urandom_range(0, 15));
            destE     = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 15));
            destM     = ($urandom_range(0, 2) == 0) ? RNONE : 4'($urandom_range(0, 15));
            valE      = {$urandom, $urandom};
            valM      = {$urandom, $urandom};
            resv_en   = ($urandom_range(0, 2) == 0);
            resv_addr = 4'($urandom_range(0, 15));
            #1;
            model_expect();
            n_checks++; if (valA !== ev_a) begin n_errors++; $display("FAIL rand_valA[%0d]: got %h expected %h", n, valA, ev_a); end
            n_checks++; if (valB !== ev_b) begin n_errors++; $display("FAIL rand_valB[%0d]: got %h expected %h", n, valB, ev_b); end
            n_checks++; if (pendA !== ep_a) begin n_errors++; $display("FAIL rand_pendA[%0d]: got %b expected %b", n, pendA, ep_a); end
            n_checks++; if (pendB !== ep_b) begin n_errors++; $display("FAIL rand_pendB[%0d]: got %b expected %b", n, pendB, ep_b); end
            n_checks++; if (stall !== e_stall) begin n_errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", n, stall, e_stall); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        destE = 4'd4; valE = 64'h44;
        destM = 4'd5; valM = 64'h55;
        resv_en = 1'b1; resv_addr = 4'd6;
        tick();
        idle();
        srcA = 4'd4;
        srcB = 4'd6;
        #1;
        n_checks++; if (valA !== 64'h44) begin n_errors++; $display("FAIL arst_pre_valA: got %h expected 44", valA); end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL arst_pre_stall: got %b expected 1", stall); end
        RST = 1'b1;
        #1;
        model_reset();
        n_checks++; if (valA !== 64'd0) begin n_errors++; $display("FAIL arst_valA: got %h expected 0", valA); end
        n_checks++; if (valB !== 64'd0) begin n_errors++; $display("FAIL arst_valB: got %h expected 0", valB); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL arst_stall: got %b expected 0", stall); end
        #1;
        RST = 1'b0;
        srcA = 4'd5;
        tick();
        #1;
        n_checks++; if (valA !== 64'd0) begin n_errors++; $display("FAIL arst_hold_valA: got %h expected 0", valA); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        srcA = 4'd0;
        srcB = 4'd0;
        test_reset();
        test_dual_write();
        test_collision();
        test_hazard();
        test_set_clear();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
